apb_master_bridge: RTL and testbench

//  APB requester: converts a valid/ready command port into APB transfers on up to
//  N_SLAVE completers, one PSEL per slave, then returns read data and error status
//  on a valid/ready response port. It is the initiator end of the NoC APB fabric,

---
 rtl/apb_master_bridge.sv | 115 +++++++++++
 tb/tb_apb_master_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to multi-completer APB requester with decode and PREADY timeout
module apb_master_bridge #(
  parameter int A_WIDTH     = 32,
  parameter int WD_WIDTH    = 32,
  parameter int RD_WIDTH    = 32,
  parameter int N_SLAVE     = 4,
  parameter int SLV_SEL_LSB = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [A_WIDTH-1:0]          cmd_addr,
  input  logic                        cmd_write,
  input  logic [WD_WIDTH-1:0]         cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [RD_WIDTH-1:0]         rsp_rdata,
  output logic                        rsp_slverr,
  output logic [A_WIDTH-1:0]          paddr,
  output logic                        pwrite,
  output logic [WD_WIDTH-1:0]         pwdata,
  output logic [N_SLAVE-1:0]          psel,
  output logic                        penable,
  input  logic [N_SLAVE*RD_WIDTH-1:0] prdata,
  input  logic [N_SLAVE-1:0]          pready,
  input  logic [N_SLAVE-1:0]          pslverr
);
  localparam int SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_idx, w_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [A_WIDTH-1:0]  r_paddr;
  logic                r_pwrite;
  logic [WD_WIDTH-1:0] r_pwdata;
  logic [RD_WIDTH-1:0] r_rdata, w_rdata_nxt, w_sel_rdata;
  logic                r_slverr, w_err_nxt, w_cap;
  logic                w_dec_err, w_sel_ready, w_sel_err, w_timeout, w_accept;
  assign w_idx       = cmd_addr[SLV_SEL_LSB +: SEL_W];
  assign w_dec_err   = 32'(w_idx) >= 32'(N_SLAVE);
  assign w_accept    = (r_state == IDLE) && cmd_valid;
  assign w_sel_ready = pready[r_idx];
  assign w_sel_err   = pslverr[r_idx];
  assign w_sel_rdata = prdata[r_idx*RD_WIDTH +: RD_WIDTH];
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign cmd_ready   = r_state == IDLE;
  assign rsp_valid   = r_state == RESP;
  assign rsp_rdata   = r_rdata;
  assign rsp_slverr  = r_slverr;
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign psel        = (r_state == SETUP || r_state == ACCESS) ? N_SLAVE'(1) << r_idx : '0;
  assign penable     = r_state == ACCESS;
  // Next state plus which response value to latch when a transfer ends
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: if (cmd_valid) begin
        w_state_nxt = w_dec_err ? RESP : SETUP;
        w_cap       = w_dec_err;
        w_err_nxt   = 1'b1;
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: if (w_sel_ready) begin
        w_state_nxt = RESP;
        w_cap       = 1'b1;
        w_rdata_nxt = r_pwrite ? '0 : w_sel_rdata;
        w_err_nxt   = w_sel_err;
      end else if (w_timeout) begin
        w_state_nxt = RESP;
        w_cap       = 1'b1;
        w_err_nxt   = 1'b1;
      end
      RESP: w_state_nxt = rsp_ready ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end
  // Command capture, response capture and ACCESS wait counter
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_idx    <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
        r_idx    <= w_idx;
      end
      if (w_cap) begin
        r_rdata  <= w_rdata_nxt;
        r_slverr <= w_err_nxt;
      end
      r_cnt <= (w_state_nxt == SETUP) ? '0 :
               (r_state == ACCESS && !w_sel_ready) ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for the APB requester bridge
module tb_apb_master_bridge;
  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_slverr;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic        pwrite, penable;
  logic [3:0]  psel, pready, pslverr;
  logic [127:0] prdata;
  logic        c3_cmd_valid, c3_cmd_ready, c3_rsp_valid, c3_rsp_slverr, c3_pwrite, c3_penable;
  logic [31:0] c3_cmd_addr, c3_rsp_rdata, c3_paddr, c3_pwdata;
  logic [2:0]  c3_psel;
  logic [32:0] q[$];
  logic [32:0] e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_rsp = 0;
  int          acc;
  always #5 clk = ~clk;
  apb_master_bridge u_dut (
    .sys_clk(clk), .sys_rstn(sys_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  apb_master_bridge #(.N_SLAVE(3)) u_dut3 (
    .sys_clk(clk), .sys_rstn(sys_rstn),
    .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_addr(c3_cmd_addr),
    .cmd_write(1'b0), .cmd_wdata(32'h0),
    .rsp_valid(c3_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(c3_rsp_rdata), .rsp_slverr(c3_rsp_slverr),
    .paddr(c3_paddr), .pwrite(c3_pwrite), .pwdata(c3_pwdata), .psel(c3_psel), .penable(c3_penable),
    .prdata({3{32'h5555_AAAA}}), .pready(3'b111), .pslverr(3'b000)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  // Response collector: compares every handshaken response with the scoreboard head
  always begin
    @(negedge clk);
    #1;
    if (sys_rstn && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[32:1]);
        chk("rsp_slverr", rsp_slverr, e[0]);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    sys_rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    rsp_ready = 1'b1; pready = '0; pslverr = '0; prdata = '0;
    c3_cmd_valid = 1'b0; c3_cmd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    sys_rstn = 1'b1;
    prdata[32 +: 32] = 32'h1234_5678;
    prdata[64 +: 32] = 32'hDEAD_BEEF;
    prdata[96 +: 32] = 32'hC0FF_EE03;
    // zero-wait write to slave 1
    pready = 4'hF;
    q.push_back({32'h0, 1'b0});
    send(32'h1004, 1'b1, 32'hA5A5_0001);
    chk("w_setup_psel", psel, 4'b0010);
    chk("w_setup_penable", penable, 0);
    chk("w_paddr", paddr, 32'h1004);
    chk("w_pwrite", pwrite, 1);
    chk("w_pwdata", pwdata, 32'hA5A5_0001);
    @(negedge clk);
    chk("w_access_psel", psel, 4'b0010);
    chk("w_access_penable", penable, 1);
    @(negedge clk);
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_resp_psel", psel, 0);
    chk("w_resp_penable", penable, 0);
    @(negedge clk);
    chk("w_idle_cmd_ready", cmd_ready, 1);
    chk("w_idle_rsp_valid", rsp_valid, 0);
    // read from slave 2 with three wait cycles; stray errors while not ready are ignored
    pready = 4'b1011;
    pslverr = 4'b0101;
    q.push_back({32'hDEAD_BEEF, 1'b0});
    send(32'h2008, 1'b0, 32'h0);
    chk("r_setup_psel", psel, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r_wait_penable", penable, 1);
      chk("r_wait_paddr", paddr, 32'h2008);
      chk("r_wait_rsp_valid", rsp_valid, 0);
    end
    @(negedge clk);
    chk("r_last_penable", penable, 1);
    chk("r_last_paddr", paddr, 32'h2008);
    pready = 4'hF;
    pslverr = 4'b0001;
    @(negedge clk);
    chk("r_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    // read from slave 3 with error; data still returned
    pslverr = 4'b1000;
    q.push_back({32'hC0FF_EE03, 1'b1});
    send(32'h3000, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("e_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    pslverr = 4'b0000;
    // timeout on slave 0
    pready = 4'b1110;
    q.push_back({32'h0, 1'b1});
    send(32'h0010, 1'b0, 32'h0);
    chk("t_setup_psel", psel, 4'b0001);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (penable) acc++;
    end
    chk("t_access_cycles", acc, 16);
    chk("t_rsp_valid", rsp_valid, 1);
    chk("t_psel_drop", psel, 0);
    @(negedge clk);
    pready = 4'hF;
    // back-pressured response: data held stable while rsp_ready is low
    rsp_ready = 1'b0;
    prdata[32 +: 32] = 32'h1111_2222;
    q.push_back({32'h1111_2222, 1'b0});
    send(32'h1100, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    prdata[32 +: 32] = 32'h9999_0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1111_2222);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", rsp_valid, 0);
    // reset asserted during ACCESS drops everything immediately
    pready = 4'b1011;
    send(32'h2100, 1'b0, 32'h0);
    @(negedge clk);
    chk("rr_access", penable, 1);
    sys_rstn = 1'b0;
    #1;
    chk("rr_psel", psel, 0);
    chk("rr_penable", penable, 0);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_cmd_ready", cmd_ready, 1);
    chk("rr_paddr", paddr, 0);
    @(negedge clk);
    sys_rstn = 1'b1;
    pready = 4'hF;
    // traffic resumes after reset
    q.push_back({32'h0, 1'b0});
    send(32'h0004, 1'b1, 32'h0BAD_F00D);
    repeat (3) @(negedge clk);
    // decode error on the 3-slave instance
    c3_cmd_valid = 1'b1;
    c3_cmd_addr = 32'h3000;
    @(negedge clk);
    c3_cmd_valid = 1'b0;
    chk("d_rsp_valid", c3_rsp_valid, 1);
    chk("d_rsp_slverr", c3_rsp_slverr, 1);
    chk("d_rsp_rdata", c3_rsp_rdata, 0);
    chk("d_psel", c3_psel, 0);
    chk("d_penable", c3_penable, 0);
    @(negedge clk);
    chk("d_after_psel", c3_psel, 0);
    chk("d_after_rsp_valid", c3_rsp_valid, 0);
    chk("d_cmd_ready", c3_cmd_ready, 1);
    repeat (2) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("rsp_count", n_rsp, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
